// File: rtl/four_to_two_encoder_pkg.sv
// Shared code constants and output bundle for the registered 4-to-2 encoder.
package four_to_two_encoder_pkg;

   localparam logic [1:0] CODE_D = 2'b00;
   localparam logic [1:0] CODE_C = 2'b01;
   localparam logic [1:0] CODE_B = 2'b10;
   localparam logic [1:0] CODE_A = 2'b11;

   typedef struct packed {
      logic [1:0] code;
      logic       valid;
      logic       err;
   } enc_out_t;

   localparam enc_out_t ENC_OUT_RST = '{code: CODE_D, valid: 1'b0, err: 1'b0};

   function automatic enc_out_t enc_out_rst();
      return ENC_OUT_RST;
   endfunction

endpackage

// File: rtl/four_to_two_encode_core.sv
// Combinational encode of {a,b,c,d} into code/valid/err.
module four_to_two_encode_core
   import four_to_two_encoder_pkg::*;
#(
   parameter bit PRIORITY_EN = 1'b1
) (
   input  logic [3:0] req_i,   // {a,b,c,d}
   output enc_out_t   enc_o
);

   logic multi;

   // Clearing the lowest set bit leaves something only if two or more are set.
   assign multi = (req_i & (req_i - 4'd1)) != 4'd0;

   always_comb begin
      enc_o = enc_out_rst();
      if (req_i == 4'd0) begin
         enc_o = enc_out_rst();
      end else if (multi && !PRIORITY_EN) begin
         enc_o.err = 1'b1;
      end else begin
         enc_o.valid = 1'b1;
         enc_o.err   = multi;
         if (req_i[3])      enc_o.code = CODE_A;
         else if (req_i[2]) enc_o.code = CODE_B;
         else if (req_i[1]) enc_o.code = CODE_C;
         else               enc_o.code = CODE_D;
      end
   end

endmodule

// File: rtl/four_to_two_encoder.sv
// Registered 4-to-2 encoder: combinational core plus one output register stage.
module four_to_two_encoder
   import four_to_two_encoder_pkg::*;
#(
   parameter bit PRIORITY_EN = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   output logic e0,
   output logic e1,
   output logic valid,
   output logic err
);

   enc_out_t out_d;
   enc_out_t out_q;

   four_to_two_encode_core #(
      .PRIORITY_EN(PRIORITY_EN)
   ) u_core (
      .req_i({a, b, c, d}),
      .enc_o(out_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out_q <= enc_out_rst();
      else        out_q <= out_d;
   end

   assign e1    = out_q.code[1];
   assign e0    = out_q.code[0];
   assign valid = out_q.valid;
   assign err   = out_q.err;

endmodule

// File: tb/tb_four_to_two_encoder.sv
// Scoreboard bench: one DUT with priority resolution, one rejecting multi-hot inputs.
module tb_four_to_two_encoder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
   logic p_e0, p_e1, p_valid, p_err;
   logic n_e0, n_e1, n_valid, n_err;

   int checks = 0;
   int failures = 0;

   // expected {e1,e0,valid,err} for the priority DUT and the rejecting DUT
   typedef struct packed {
      logic [3:0] exp_p;
      logic [3:0] exp_n;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   four_to_two_encoder #(.PRIORITY_EN(1'b1)) u_dut_p (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
      .e0(p_e0), .e1(p_e1), .valid(p_valid), .err(p_err)
   );

   four_to_two_encoder #(.PRIORITY_EN(1'b0)) u_dut_n (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
      .e0(n_e0), .e1(n_e1), .valid(n_valid), .err(n_err)
   );

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got {e1,e0,valid,err}=%b expected %b", name, act, exp);
      end
   endtask

   // Monitor: every cycle the DUTs present a fresh output, compare against the scoreboard.
   always @(posedge clk) begin
      #1;
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check("prio", {p_e1, p_e0, p_valid, p_err}, e.exp_p);
         check("noprio", {n_e1, n_e0, n_valid, n_err}, e.exp_n);
      end
   end

   task automatic step(input logic rst, input logic [3:0] abcd,
                       input logic [3:0] exp_p, input logic [3:0] exp_n);
      @(negedge clk);
      rst_n = rst;
      {a, b, c, d} = abcd;
      sb_q.push_back('{exp_p: exp_p, exp_n: exp_n});
   endtask

   initial begin
      // reset held with a=1: outputs must stay clear
      for (int i = 0; i < 3; i++) step(1'b0, 4'b1000, 4'b0000, 4'b0000);
      step(1'b1, 4'b1000, 4'b1110, 4'b1110);

      // one-hot sweep d, c, b, a
      for (int i = 0; i < 3; i++) step(1'b1, 4'b0001, 4'b0010, 4'b0010);
      for (int i = 0; i < 3; i++) step(1'b1, 4'b0010, 4'b0110, 4'b0110);
      for (int i = 0; i < 3; i++) step(1'b1, 4'b0100, 4'b1010, 4'b1010);
      for (int i = 0; i < 3; i++) step(1'b1, 4'b1000, 4'b1110, 4'b1110);

      // zero-hot
      step(1'b1, 4'b0000, 4'b0000, 4'b0000);

      // multi-hot: priority wins vs rejected
      step(1'b1, 4'b0101, 4'b1011, 4'b0001);
      step(1'b1, 4'b1111, 4'b1111, 4'b0001);
      step(1'b1, 4'b0011, 4'b0111, 4'b0001);
      step(1'b1, 4'b0010, 4'b0110, 4'b0110);
      step(1'b1, 4'b1001, 4'b1111, 4'b0001);

      // async reset between edges while outputs show a code
      step(1'b1, 4'b0010, 4'b0110, 4'b0110);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_prio", {p_e1, p_e0, p_valid, p_err}, 4'b0000);
      check("async_rst_noprio", {n_e1, n_e0, n_valid, n_err}, 4'b0000);
      step(1'b0, 4'b0010, 4'b0000, 4'b0000);
      step(1'b1, 4'b0010, 4'b0110, 4'b0110);
      step(1'b1, 4'b0000, 4'b0000, 4'b0000);

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
